// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, memory-wait
// holds with timeout, interrupt acceptance and a saturating stall statistic.
module pipe_hazard_ctrl (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_rt,
  input  logic        ID_Jump,
  input  logic        EX_BranchTaken,
  input  logic        MEM_Busy,
  input  logic        IRQ,
  input  logic        IntEn,
  input  logic        ID_Eret,
  output logic        PC_Hold,
  output logic        IF_Protect,
  output logic        IF_Flush,
  output logic        ID_Flush,
  output logic        Pipe_Hold,
  output logic        IntAccept,
  output logic        MemTimeout,
  output logic        IntActive,
  output logic [15:0] StallCnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       int_nxt;
  logic       load_use;

  // $zero is never a real producer, so a load into it cannot create a hazard
  assign load_use = EX_MemRd && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (ID_UsesRt && (EX_rt == ID_rt)));

  always_comb begin
    PC_Hold    = 1'b0;
    IF_Protect = 1'b0;
    IF_Flush   = 1'b0;
    ID_Flush   = 1'b0;
    Pipe_Hold  = 1'b0;
    IntAccept  = 1'b0;
    MemTimeout = 1'b0;
    state_nxt  = RUN;
    wait_nxt   = '0;
    int_nxt    = ID_Eret ? 1'b0 : IntActive;
    if (Reset_n) begin
      if (MEM_Busy) begin
        if (wait_cnt == 4'hF) begin
          MemTimeout = 1'b1;
        end else begin
          PC_Hold    = 1'b1;
          IF_Protect = 1'b1;
          Pipe_Hold  = 1'b1;
          state_nxt  = MEM_WAIT;
          wait_nxt   = wait_cnt + 4'd1;
        end
      end else if (EX_BranchTaken) begin
        IF_Flush = 1'b1;
        ID_Flush = 1'b1;
      end else if ((state == RUN) && load_use) begin
        PC_Hold    = 1'b1;
        IF_Protect = 1'b1;
        ID_Flush   = 1'b1;
        state_nxt  = LU_STALL;
      end else if (ID_Jump) begin
        IF_Flush = 1'b1;
      end else if ((state == RUN) && IRQ && IntEn && !IntActive) begin
        IntAccept = 1'b1;
        IF_Flush  = 1'b1;
        int_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      IntActive <= 1'b0;
      StallCnt  <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      IntActive <= int_nxt;
      if (PC_Hold && (StallCnt != 16'hFFFF))
        StallCnt <= StallCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a cycle-level
// reference model built from the hazard priority rules.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        ID_UsesRt, EX_MemRd, ID_Jump, EX_BranchTaken, MEM_Busy;
  logic        IRQ, IntEn, ID_Eret;
  logic        PC_Hold, IF_Protect, IF_Flush, ID_Flush, Pipe_Hold;
  logic        IntAccept, MemTimeout, IntActive;
  logic [15:0] StallCnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRd(EX_MemRd), .EX_rt(EX_rt),
    .ID_Jump(ID_Jump), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Busy(MEM_Busy), .IRQ(IRQ), .IntEn(IntEn), .ID_Eret(ID_Eret),
    .PC_Hold(PC_Hold), .IF_Protect(IF_Protect), .IF_Flush(IF_Flush),
    .ID_Flush(ID_Flush), .Pipe_Hold(Pipe_Hold), .IntAccept(IntAccept),
    .MemTimeout(MemTimeout), .IntActive(IntActive), .StallCnt(StallCnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, tag, obs, exp);
    end
  endtask

  // Reference model history
  int busy_run;     // consecutive busy cycles in the current wait window
  bit was_waiting;  // previous cycle held the pipe for memory
  bit was_lu;       // previous cycle was a load-use stall
  bit isr_on;
  int stalls;

  initial begin
    int  burst;
    bit  run_ok, hazard;
    bit  e_pch, e_ifp, e_iff, e_idf, e_pph, e_acc, e_to;

    Reset_n = 1'b0; ID_rs = '0; ID_rt = '0; EX_rt = '0; ID_UsesRt = 0;
    EX_MemRd = 0; ID_Jump = 0; EX_BranchTaken = 0; MEM_Busy = 0;
    IRQ = 0; IntEn = 0; ID_Eret = 0;
    busy_run = 0; was_waiting = 0; was_lu = 0; isr_on = 0; stalls = 0;
    burst = 0;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      cyc = i;
      Reset_n        = ($urandom_range(0, 249) != 0);
      ID_rs          = 5'($urandom_range(0, 3));
      ID_rt          = 5'($urandom_range(0, 3));
      EX_rt          = 5'($urandom_range(0, 3));
      ID_UsesRt      = 1'($urandom_range(0, 1));
      EX_MemRd       = 1'($urandom_range(0, 1));
      EX_BranchTaken = ($urandom_range(0, 7) == 0);
      ID_Jump        = ($urandom_range(0, 5) == 0);
      IntEn          = ($urandom_range(0, 4) != 0);
      ID_Eret        = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) IRQ = ~IRQ;
      if (burst > 0) begin
        MEM_Busy = 1'b1;
        burst--;
      end else if ($urandom_range(0, 39) == 0) begin
        burst = $urandom_range(5, 22);
        MEM_Busy = 1'b1;
      end else begin
        MEM_Busy = ($urandom_range(0, 9) == 0);
      end
      #2;

      {e_pch, e_ifp, e_iff, e_idf, e_pph, e_acc, e_to} = '0;
      hazard = EX_MemRd && EX_rt != 0 &&
               (EX_rt == ID_rs || (ID_UsesRt && EX_rt == ID_rt));
      run_ok = !was_waiting && !was_lu;
      if (Reset_n) begin
        if (MEM_Busy && busy_run == 15) e_to = 1;
        else if (MEM_Busy) {e_pch, e_ifp, e_pph} = 3'b111;
        else if (EX_BranchTaken) {e_iff, e_idf} = 2'b11;
        else if (run_ok && hazard) {e_pch, e_ifp, e_idf} = 3'b111;
        else if (ID_Jump) e_iff = 1;
        else if (run_ok && IRQ && IntEn && !isr_on) {e_acc, e_iff} = 2'b11;
      end

      chk("PC_Hold",    16'(PC_Hold),    16'(e_pch));
      chk("IF_Protect", 16'(IF_Protect), 16'(e_ifp));
      chk("IF_Flush",   16'(IF_Flush),   16'(e_iff));
      chk("ID_Flush",   16'(ID_Flush),   16'(e_idf));
      chk("Pipe_Hold",  16'(Pipe_Hold),  16'(e_pph));
      chk("IntAccept",  16'(IntAccept),  16'(e_acc));
      chk("MemTimeout", 16'(MemTimeout), 16'(e_to));
      chk("IntActive",  16'(IntActive),  16'(isr_on));
      chk("StallCnt",   StallCnt,        16'(stalls));

      if (!Reset_n) begin
        busy_run = 0; was_waiting = 0; was_lu = 0; isr_on = 0; stalls = 0;
      end else begin
        if (e_pch && stalls < 65535) stalls++;
        if (e_acc) isr_on = 1;
        else if (ID_Eret) isr_on = 0;
        was_lu      = !MEM_Busy && !EX_BranchTaken && run_ok && hazard;
        was_waiting = e_pph;
        busy_run    = e_pph ? busy_run + 1 : 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
